// File: rtl/pw_update.sv
// pw_update: collects a new 6-digit password twice, writes it to the password RAM and verifies it by readback
//   clk          system clock
//   rst          asynchronous active-low reset
//   pwdigit      password digit, taken on pwenter
//   pwenter      single-cycle digit strobe
//   change_req   single-cycle password change request
//   log_in_ctrl  user logged in (level); dropping it aborts a change
//   isGuest_ctrl logged-in user is a guest (level)
//   intID_ctrl   internal ID of the logged-in user, latched at request time
//   q_PW_RAM     RAM read data
//   addr_PW_RAM  RAM address {2'b00, latched ID}
//   data_PW_RAM  RAM write data
//   wren_PW_RAM  RAM write strobe, one cycle
//   busy         high whenever not idle
//   done         one-cycle pulse on a verified write
//   fail         one-cycle pulse on a rejected or failed change
//   fail_code    01 mismatch, 10 readback error, 11 denied; holds until the next fail
module pw_update #(
   parameter int RD_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  pwdigit,
   input  logic        pwenter,
   input  logic        change_req,
   input  logic        log_in_ctrl,
   input  logic        isGuest_ctrl,
   input  logic [2:0]  intID_ctrl,
   input  logic [23:0] q_PW_RAM,
   output logic [4:0]  addr_PW_RAM,
   output logic [23:0] data_PW_RAM,
   output logic        wren_PW_RAM,
   output logic        busy,
   output logic        done,
   output logic        fail,
   output logic [1:0]  fail_code
);
   localparam logic [3:0] IDLE     = 4'd0;
   localparam logic [3:0] NEW      = 4'd1;
   localparam logic [3:0] CONF     = 4'd2;
   localparam logic [3:0] COMPARE  = 4'd3;
   localparam logic [3:0] WRITE    = 4'd4;
   localparam logic [3:0] RB1      = 4'd5;
   localparam logic [3:0] RB2      = 4'd6;
   localparam logic [3:0] RB_CATCH = 4'd7;
   localparam logic [3:0] VERIFY   = 4'd8;

   logic [3:0]  state;
   logic [2:0]  cnt;
   logic [2:0]  id;
   logic [23:0] new_pw;
   logic [23:0] conf_pw;
   logic [23:0] rb_pw;

   assign busy = state != IDLE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         id          <= '0;
         new_pw      <= '0;
         conf_pw     <= '0;
         rb_pw       <= '0;
         addr_PW_RAM <= '0;
         data_PW_RAM <= '0;
         wren_PW_RAM <= 1'b0;
         done        <= 1'b0;
         fail        <= 1'b0;
         fail_code   <= '0;
      end else begin
         done <= 1'b0;
         fail <= 1'b0;
         // logout wins over everything, including a write about to be issued
         if (state != IDLE && !log_in_ctrl) begin
            state       <= IDLE;
            wren_PW_RAM <= 1'b0;
         end else begin
            case (state)
               IDLE: if (change_req) begin
                  if (log_in_ctrl && !isGuest_ctrl) begin
                     id      <= intID_ctrl;
                     new_pw  <= '0;
                     conf_pw <= '0;
                     cnt     <= '0;
                     state   <= NEW;
                  end else begin
                     fail      <= 1'b1;
                     fail_code <= 2'b11;
                  end
               end
               NEW: if (pwenter) begin
                  new_pw <= {new_pw[19:0], pwdigit};
                  cnt    <= cnt == 3'd5 ? 3'd0 : cnt + 3'd1;
                  state  <= cnt == 3'd5 ? CONF : NEW;
               end
               CONF: if (pwenter) begin
                  conf_pw <= {conf_pw[19:0], pwdigit};
                  cnt     <= cnt == 3'd5 ? 3'd0 : cnt + 3'd1;
                  state   <= cnt == 3'd5 ? COMPARE : CONF;
               end
               COMPARE: if (new_pw == conf_pw) begin
                  wren_PW_RAM <= 1'b1;
                  addr_PW_RAM <= {2'b00, id};
                  data_PW_RAM <= new_pw;
                  state       <= WRITE;
               end else begin
                  fail      <= 1'b1;
                  fail_code <= 2'b01;
                  state     <= IDLE;
               end
               WRITE: begin
                  wren_PW_RAM <= 1'b0;
                  state       <= RB1;
               end
               RB1: begin
                  cnt   <= '0;
                  state <= RB2;
               end
               // RB2 stretches for longer RAM latencies so q is valid when RB_CATCH ends
               RB2: begin
                  cnt   <= cnt + 3'd1;
                  state <= cnt == 3'(RD_LAT - 3) ? RB_CATCH : RB2;
               end
               RB_CATCH: begin
                  rb_pw <= q_PW_RAM;
                  state <= VERIFY;
               end
               VERIFY: begin
                  done      <= rb_pw == new_pw;
                  fail      <= rb_pw != new_pw;
                  fail_code <= rb_pw != new_pw ? 2'b10 : fail_code;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/pw_update.md
# pw_update

Password-change writer for the login subsystem. Once a non-guest user is logged in, the block collects a new 6-digit password twice: once as entry, once as confirmation. On a match it writes the 24-bit value into the shared password RAM at the user's slot, then reads it back through the RAM's 3-cycle read path to verify it. It sits beside the password checker and drives the write side of the same store the checker reads.

## Interface
Parameters:
- RD_LAT, 3, RAM read latency in clocks from stable address to valid q.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-low.
- pwdigit  in  4  password digit from the toggle switches.
- pwenter  in  1  single-cycle pulse from the button shaper; accepts pwdigit.
- change_req  in  1  single-cycle pulse; requests a password change.
- log_in_ctrl  in  1  level; user currently logged in.
- isGuest_ctrl  in  1  level; logged-in user is a guest.
- intID_ctrl  in  3  internal ID of the logged-in user.
- q_PW_RAM  in  24  RAM read data.
- addr_PW_RAM  out  5  RAM address, {2'b00, latched ID}.
- data_PW_RAM  out  24  RAM write data.
- wren_PW_RAM  out  1  RAM write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on a verified write.
- fail  out  1  one-cycle pulse on a rejected or failed change.
- fail_code  out  2  01 = confirm mismatch, 10 = readback error, 11 = denied. Valid while fail=1; holds its value until the next fail.

## Operation
- All outputs and registers are registered and reset to 0. State resets to IDLE.
- States: IDLE, NEW (digit count 0..5), CONF (digit count 0..5), COMPARE, WRITE, RB1, RB2, RB_CATCH, VERIFY.
- **IDLE, change_req=1:**
  - If log_in_ctrl=1 and isGuest_ctrl=0: latch intID_ctrl, clear both shift registers and the count, go to NEW.
  - Otherwise: fail=1, fail_code=11, stay in IDLE.
- **NEW and CONF:** each pwenter loads pwdigit MSB-first. Digit 1 goes to [23:20], digit 6 to [3:0]. The 6th digit in NEW moves to CONF with the count cleared. The 6th digit in CONF moves to COMPARE.
- **COMPARE:**
  - new == confirm: go to WRITE, setting wren=1, addr={2'b00,ID}, data=new.
  - Otherwise: fail=1, fail_code=01, go to IDLE. The RAM is untouched.
- **WRITE:** wren is cleared on exit. addr and data hold through VERIFY.
- **RB1, RB2, RB_CATCH:** address stays stable. RB_CATCH captures q_PW_RAM on its exit edge.
- **VERIFY:**
  - Captured value == new: done=1.
  - Otherwise: fail=1, fail_code=10.
  - Either way, go to IDLE.
- **Abort:** log_in_ctrl=0 in any non-IDLE state forces IDLE on the next edge. wren is cleared, no done/fail pulse is raised, and no write is issued after the abort edge.
- **Ignored inputs:**
  - pwenter outside NEW/CONF.
  - change_req outside IDLE.
  - change_req and pwenter together in IDLE: change_req is accepted, pwenter is dropped.
- Guest status and ID are checked only at request time. ID changes during the operation are ignored.

## Timing
- Edge E0 samples the 12th pwenter; the state becomes COMPARE.
- **E1:** fail pulse for a mismatch, otherwise wren=1 (exactly one cycle, E1 to E2).
- **E2:** RB1. **E3:** RB2. **E4:** RB_CATCH. **E5:** q captured, VERIFY.
- **E6:** done or fail high for one cycle, busy low.
- **Latency:**
  - Match: 6 clocks from the last pwenter to done.
  - Mismatch: 1 clock from the last pwenter to fail.
- **Denied request:** fail is high on the edge after change_req.
- **Reset:** asynchronous assert mid-operation clears wren immediately. Outputs are 0 and the state is IDLE until the first clk edge after deassertion.

## Test plan
- **Good change:** logged-in ID=3, non-guest; change_req, digits 1,2,3,4,5,6 twice, RAM model returns the written data -> wren one cycle with addr=5'd3 and data=24'h123456, done 6 cycles after the last pwenter, fail never asserted.
- **Mismatch:** new 123456, confirm 123457 -> fail=1 with fail_code=01 one cycle after the last pwenter, wren never asserted.
- **Guest:** isGuest_ctrl=1, change_req -> fail_code=11, busy stays 0; a logged-out request also gives fail_code=11.
- **Readback corrupt:** RAM model returns 24'h000000 after the write -> fail with fail_code=10 at E6, done=0.
- **Abort:** log_in_ctrl drops after the 8th digit -> IDLE next cycle, no pulses, no write; a new change_req then restarts at digit 1.
- **Async reset:** assert rst=0 during WRITE -> wren low without a clock edge, all outputs 0.
